// File: rtl/ising_job_sequencer_pkg.sv
// ising_job_sequencer_pkg: shared ising_axi address map and sequencer state encoding.
// Holds the register addresses of the attached ising_axi block and the state
// encoding used by ising_job_sequencer, so neither is redefined locally.
package ising_job_sequencer_pkg;
  localparam logic [31:0] START_ADDR       = 32'h0000_0000;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;
  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0010_0000;
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CFG_CUT = 4'd1;
  localparam logic [3:0] ST_CFG_MAX = 4'd2;
  localparam logic [3:0] ST_LOAD    = 4'd3;
  localparam logic [3:0] ST_START   = 4'd4;
  localparam logic [3:0] ST_RUN     = 4'd5;
  localparam logic [3:0] ST_RD_ADDR = 4'd6;
  localparam logic [3:0] ST_RD_DATA = 4'd7;
  localparam logic [3:0] ST_EMIT    = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;
  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    CFG_CUT = ST_CFG_CUT,
    CFG_MAX = ST_CFG_MAX,
    LOAD    = ST_LOAD,
    START   = ST_START,
    RUN     = ST_RUN,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA,
    EMIT    = ST_EMIT,
    DONE    = ST_DONE
  } state_e;
endpackage

// File: rtl/ising_job_sequencer.sv
// ising_job_sequencer: drives one Ising job through ising_axi (configure, load edges, run, read phases).
// Ports:
//   clk, axi_rstn                 clock, asynchronous active-low reset
//   job_start, cfg_cutoff/max     job launch pulse and counter settings (sampled at launch)
//   edge_*                        upper-triangular edge stream (edge_last ends loading)
//   wready, wr_addr, wdata        single-cycle write port into ising_axi
//   araddr, rdata                 read port, one-cycle read latency
//   res_*                         per-spin result stream (phase and thresholded spin)
//   busy, done, err               status: not idle, end-of-job pulse, sticky bad-edge flag
module ising_job_sequencer
  import ising_job_sequencer_pkg::*;
#(
  parameter int          N           = 8,
  parameter int          NUM_WEIGHTS = 3,
  parameter int          RUN_CYCLES  = 600,
  parameter logic [31:0] START_DATA  = 32'h0000_0010
) (
  input  logic                   clk,
  input  logic                   axi_rstn,
  input  logic                   job_start,
  input  logic [31:0]            cfg_cutoff,
  input  logic [31:0]            cfg_max,
  input  logic                   edge_valid,
  output logic                   edge_ready,
  input  logic [$clog2(N)-1:0]   edge_i,
  input  logic [$clog2(N)-1:0]   edge_j,
  input  logic [NUM_WEIGHTS-1:0] edge_w,
  input  logic                   edge_last,
  output logic                   wready,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wdata,
  output logic [31:0]            araddr,
  input  logic [31:0]            rdata,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(N)-1:0]   res_idx,
  output logic [31:0]            res_phase,
  output logic                   res_spin,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int              KW       = $clog2(N);
  localparam logic [KW-1:0]   K_LAST   = KW'(N - 1);
  localparam logic [31:0]     RUN_LAST = 32'(RUN_CYCLES - 1);
  state_e          state_q, state_d;
  logic [31:0]     cut_q, cut_d, max_q, max_d, cnt_q, cnt_d, phase_q, phase_d;
  logic [KW-1:0]   k_q, k_d;
  logic            spin_q, spin_d, err_q, err_d;
  logic [31:0]     rd_addr;
  // Phases are read highest slot first, so result k comes from slot N-1-k.
  assign rd_addr   = PHASE_ADDR_BASE + ((32'(N - 1) - 32'(k_q)) << 2);
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign res_idx   = k_q;
  assign res_phase = phase_q;
  assign res_spin  = spin_q;
  always_comb begin
    state_d    = state_q;
    cut_d      = cut_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    k_d        = k_q;
    spin_d     = spin_q;
    err_d      = err_q;
    wready     = 1'b0;
    wr_addr    = 32'd0;
    wdata      = 32'd0;
    araddr     = 32'd0;
    edge_ready = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      IDLE: if (job_start) begin
        state_d = CFG_CUT;
        cut_d   = cfg_cutoff;
        max_d   = cfg_max;
        err_d   = 1'b0;
        k_d     = '0;
      end
      CFG_CUT: begin
        wready  = 1'b1;
        wr_addr = CTR_CUTOFF_ADDR;
        wdata   = cut_q;
        state_d = CFG_MAX;
      end
      CFG_MAX: begin
        wready  = 1'b1;
        wr_addr = CTR_MAX_ADDR;
        wdata   = max_q;
        state_d = LOAD;
      end
      LOAD: begin
        edge_ready = 1'b1;
        // Lower-triangle edges are swallowed and flagged; the diagonal carries the initial spin.
        if (edge_valid) begin
          err_d   = (edge_i > edge_j) ? 1'b1 : err_q;
          wready  = edge_i <= edge_j;
          wr_addr = WEIGHT_ADDR_BASE + (32'(edge_i) << 2) + (32'(edge_j) << 13);
          wdata   = 32'(edge_w);
          state_d = edge_last ? START : LOAD;
        end
      end
      START: begin
        wready  = 1'b1;
        wr_addr = START_ADDR;
        wdata   = START_DATA;
        cnt_d   = 32'd0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d   = (cnt_q == RUN_LAST) ? cnt_q : cnt_q + 32'd1;
        k_d     = (cnt_q == RUN_LAST) ? '0 : k_q;
        state_d = (cnt_q == RUN_LAST) ? RD_ADDR : RUN;
      end
      RD_ADDR: begin
        araddr  = rd_addr;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        araddr  = rd_addr;
        phase_d = rdata;
        spin_d  = rdata >= cut_q;
        state_d = EMIT;
      end
      EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = (k_q == K_LAST) ? DONE : RD_ADDR;
          k_d     = (k_q == K_LAST) ? k_q : k_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= IDLE;
      cut_q   <= 32'd0;
      max_q   <= 32'd0;
      cnt_q   <= 32'd0;
      phase_q <= 32'd0;
      k_q     <= '0;
      spin_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cut_q   <= cut_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      k_q     <= k_d;
      spin_q  <= spin_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ising_job_sequencer.sv
// tb_ising_job_sequencer: scoreboard bench for ising_job_sequencer with a behavioural phase memory.
module tb_ising_job_sequencer;
  import ising_job_sequencer_pkg::*;
  localparam int N  = 8;
  localparam int NW = 3;
  localparam int RC = 20;
  logic        clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        job_start = 1'b0;
  logic [31:0] cfg_cutoff = 32'd0;
  logic [31:0] cfg_max = 32'd0;
  logic        edge_valid = 1'b0;
  logic        edge_ready;
  logic [2:0]  edge_i = 3'd0;
  logic [2:0]  edge_j = 3'd0;
  logic [2:0]  edge_w = 3'd0;
  logic        edge_last = 1'b0;
  logic        wready;
  logic [31:0] wr_addr, wdata, araddr, rdata;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  res_idx;
  logic [31:0] res_phase;
  logic        res_spin, busy, done, err;
  int tests = 0;
  int fails = 0;
  logic [31:0] phase_mem [N];
  int ei_a [16];
  int ej_a [16];
  int ew_a [16];
  logic [63:0] wq [$];
  logic [63:0] rq [$];

  always #5 clk = ~clk;

  ising_job_sequencer #(.N(N), .NUM_WEIGHTS(NW), .RUN_CYCLES(RC), .START_DATA(32'h0000_0010)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .job_start(job_start), .cfg_cutoff(cfg_cutoff), .cfg_max(cfg_max),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_i(edge_i), .edge_j(edge_j), .edge_w(edge_w),
    .edge_last(edge_last), .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .araddr(araddr), .rdata(rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_phase(res_phase), .res_spin(res_spin),
    .busy(busy), .done(done), .err(err)
  );

  // ising_axi phase read port model: one-cycle read latency
  always @(posedge clk) rdata <= phase_mem[3'((araddr - PHASE_ADDR_BASE) >> 2)];

  function automatic logic [31:0] waddr(input int i, input int j);
    return WEIGHT_ADDR_BASE + 32'(i * 4 + j * 8192);
  endfunction

  task automatic push_results(input logic [31:0] cut);
    for (int k = 0; k < N; k++) begin
      logic [31:0] ph;
      ph = phase_mem[N - 1 - k];
      rq.push_back({28'd0, ph >= cut, 3'(k), ph});
    end
  endtask

  task automatic drive_job(input logic [31:0] cut, input logic [31:0] mx, input int ne, input int bp,
                           input int dup_cyc, input int abort_after, output int done_cnt);
    int ei, bp_left, stall_n, start_seen, cyc;
    logic finished;
    logic [63:0] exp, cur, snap;
    ei = 0; bp_left = bp; stall_n = 0; start_seen = -1; done_cnt = 0; finished = 1'b0; snap = '0;
    cfg_cutoff = cut;
    cfg_max = mx;
    for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      job_start = (cyc == 0) || (cyc == dup_cyc);
      edge_valid = ei < ne;
      if (ei < ne) begin
        edge_i = 3'(ei_a[ei]);
        edge_j = 3'(ej_a[ei]);
        edge_w = 3'(ew_a[ei]);
        edge_last = (ei == ne - 1);
      end
      res_ready = !(res_valid && bp_left > 0);
      #1;
      if (wready) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write", wr_addr, wdata);
        end else begin
          exp = wq.pop_front();
          if ({wr_addr, wdata} !== exp) begin
            fails++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", wr_addr, wdata, exp[63:32], exp[31:0]);
          end
          if (wq.size() == 0) start_seen = cyc;
        end
      end
      if (edge_valid && edge_ready) ei++;
      if (!res_valid && stall_n > 0) begin
        tests++;
        fails++;
        $display("FAIL res_valid_hold: got 0 during stall, required 1");
        stall_n = 0;
      end
      if (res_valid) begin
        cur = {28'd0, res_spin, res_idx, res_phase};
        if (stall_n > 0) begin
          tests++;
          if (cur !== snap) begin
            fails++;
            $display("FAIL res_stable: got %h, required %h", cur, snap);
          end
        end
        snap = cur;
        if (!res_ready) begin
          stall_n++;
          bp_left--;
        end else begin
          stall_n = 0;
          tests++;
          if (rq.size() == 0) begin
            fails++;
            $display("FAIL result_unexpected: got idx=%0d phase=%0d spin=%b, required none", res_idx, res_phase, res_spin);
          end else begin
            exp = rq.pop_front();
            if (cur !== exp) begin
              fails++;
              $display("FAIL result: got idx=%0d phase=%0d spin=%b, required idx=%0d phase=%0d spin=%b",
                       res_idx, res_phase, res_spin, exp[34:32], exp[31:0], exp[35]);
            end
          end
        end
      end
      if (done) done_cnt++;
      if (done_cnt > 0 && !done && !busy) finished = 1'b1;
      if (abort_after > 0 && start_seen >= 0 && cyc == start_seen + abort_after) begin
        axi_rstn = 1'b0;
        #1;
        tests++;
        if ({busy, done, wready, edge_ready, res_valid} !== 5'b0 || araddr !== 32'd0) begin
          fails++;
          $display("FAIL async_reset: got busy/done/wready/edge_ready/res_valid=%b araddr=%h, required 0",
                   {busy, done, wready, edge_ready, res_valid}, araddr);
        end
        finished = 1'b1;
      end
    end
    job_start = 1'b0;
    edge_valid = 1'b0;
    res_ready = 1'b0;
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL job_timeout: got no completion in %0d cycles, required done", cyc);
    end
    tests++;
    if (wq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d writes %0d results pending, required 0", wq.size(), rq.size());
    end
    wq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    axi_rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, err, wready, edge_ready, res_valid, res_spin} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 0", {busy, done, err, wready, edge_ready, res_valid, res_spin});
    end
    tests++;
    if ({wr_addr, wdata, araddr, res_phase} !== 128'b0) begin
      fails++;
      $display("FAIL reset_buses: got wr_addr=%h wdata=%h araddr=%h res_phase=%h, required 0", wr_addr, wdata, araddr, res_phase);
    end
    tests++;
    if (res_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_idx: got %0d, required 0", res_idx);
    end
    @(negedge clk);
    axi_rstn = 1'b1;
  endtask

  task automatic test_basic_job();
    int dc;
    phase_mem = '{32'd3, 32'd4, 32'd5, 32'd0, 32'd9, 32'd2, 32'd4, 32'd7};
    ei_a[0] = 0; ej_a[0] = 1; ew_a[0] = 1;
    ei_a[1] = 0; ej_a[1] = 7; ew_a[1] = 4;
    wq.push_back({CTR_CUTOFF_ADDR, 32'd4});
    wq.push_back({CTR_MAX_ADDR, 32'd8});
    wq.push_back({WEIGHT_ADDR_BASE + 32'h2000, 32'd1});
    wq.push_back({WEIGHT_ADDR_BASE + 32'hE000, 32'd4});
    wq.push_back({START_ADDR, 32'h10});
    push_results(32'd4);
    drive_job(32'd4, 32'd8, 2, 0, -1, 0, dc);
    tests++;
    if (dc !== 1) begin
      fails++;
      $display("FAIL basic_done_count: got %0d, required 1", dc);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL basic_err: got %b, required 0", err);
    end
  endtask

  task automatic test_bad_edge();
    int dc;
    phase_mem = '{32'd9, 32'd8, 32'd10, 32'd0, 32'd100, 32'd9, 32'd1, 32'd8};
    ei_a[0] = 3; ej_a[0] = 2; ew_a[0] = 5;
    ei_a[1] = 2; ej_a[1] = 2; ew_a[1] = 1;
    ei_a[2] = 2; ej_a[2] = 5; ew_a[2] = 3;
    wq.push_back({CTR_CUTOFF_ADDR, 32'd9});
    wq.push_back({CTR_MAX_ADDR, 32'd16});
    wq.push_back({waddr(2, 2), 32'd1});
    wq.push_back({waddr(2, 5), 32'd3});
    wq.push_back({START_ADDR, 32'h10});
    push_results(32'd9);
    drive_job(32'd9, 32'd16, 3, 0, -1, 0, dc);
    tests++;
    if (dc !== 1) begin
      fails++;
      $display("FAIL bad_edge_done_count: got %0d, required 1", dc);
    end
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL bad_edge_err: got %b, required 1", err);
    end
  endtask

  task automatic test_maxcut_backpressure();
    int dc, idle_bad;
    logic [31:0] ph [N];
    ph = '{32'd150, 32'd20, 32'd120, 32'd180, 32'd60, 32'd30, 32'd200, 32'd100};
    for (int k = 0; k < N; k++) phase_mem[N - 1 - k] = ph[k];
    ei_a[0] = 0; ej_a[0] = 1; ew_a[0] = 7;
    ei_a[1] = 1; ej_a[1] = 2; ew_a[1] = 7;
    ei_a[2] = 2; ej_a[2] = 3; ew_a[2] = 7;
    ei_a[3] = 3; ej_a[3] = 4; ew_a[3] = 7;
    ei_a[4] = 0; ej_a[4] = 4; ew_a[4] = 7;
    @(negedge clk);
    #1;
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    wq.push_back({CTR_CUTOFF_ADDR, 32'd100});
    wq.push_back({CTR_MAX_ADDR, 32'd64});
    for (int e = 0; e < 5; e++) wq.push_back({waddr(ei_a[e], ej_a[e]), 32'd7});
    wq.push_back({START_ADDR, 32'h10});
    push_results(32'd100);
    tests++;
    if (rq[0][35] !== rq[2][35] || rq[0][35] !== rq[3][35] || rq[1][35] !== rq[4][35] || rq[0][35] === rq[1][35]) begin
      fails++;
      $display("FAIL maxcut_setup: got spins %b%b%b%b%b, required A=C=D!=B=E", rq[0][35], rq[1][35], rq[2][35], rq[3][35], rq[4][35]);
    end
    drive_job(32'd100, 32'd64, 5, 5, 12, 0, dc);
    tests++;
    if (dc !== 1) begin
      fails++;
      $display("FAIL maxcut_done_count: got %0d, required 1", dc);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared: got %b, required 0", err);
    end
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (busy || wready) idle_bad++;
    end
    tests++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL start_not_queued: got %0d busy cycles after done, required 0", idle_bad);
    end
  endtask

  task automatic test_reset_in_run();
    int dc, bad;
    ei_a[0] = 1; ej_a[0] = 3; ew_a[0] = 2;
    wq.push_back({CTR_CUTOFF_ADDR, 32'd5});
    wq.push_back({CTR_MAX_ADDR, 32'd6});
    wq.push_back({waddr(1, 3), 32'd2});
    wq.push_back({START_ADDR, 32'h10});
    drive_job(32'd5, 32'd6, 1, 0, -1, 5, dc);
    repeat (2) @(negedge clk);
    axi_rstn = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (busy || wready || res_valid || done) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_abandon: got %0d active cycles after reset, required 0", bad);
    end
    tests++;
    if (dc !== 0) begin
      fails++;
      $display("FAIL reset_abandon_done: got %0d done pulses, required 0", dc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_bad_edge();
    test_maxcut_backpressure();
    test_reset_in_run();
    test_basic_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
